pipe_hs_stage: RTL and testbench

//  Generic, parametrised inter-stage pipeline register for the PIPELINECPU datapath.
//  It is the handshake-capable successor to the fixed-field stage registers.
//  - Carries a control bundle and a data bundle through STAGES register slots.
//  - Adds valid/ready flow control, stall (backpressure) with an optional skid buffer, and flush.
//  - Any invalid slot presents all-zero control, so bubbles never write regs or memory.
//  - Sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_hs_slot.sv | 88 ++++++++
 rtl/pipe_hs_stage.sv | 76 +++++++
 tb/tb_pipe_hs_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the handshake pipeline stage registers
package pipe_pkg;

  localparam int STAGE_MAX = 4;

  // Default layout of the control bundle as produced by the decoder
  localparam int CTRL_WREG   = 0;
  localparam int CTRL_M2REG  = 1;
  localparam int CTRL_WMEM   = 2;
  localparam int CTRL_ALUC   = 3;
  localparam int CTRL_ALUC_W = 4;

  function automatic int clamp_stages(input int s);
    if (s < 1) return 1;
    if (s > STAGE_MAX) return STAGE_MAX;
    return s;
  endfunction

endpackage

// File: rtl/pipe_hs_slot.sv
// rtl/pipe_hs_slot.sv - one valid/ready register slot with optional skid entry
module pipe_hs_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data
);

  logic              mv_q, mv_d, sv_q, sv_d;
  logic [CTRL_W-1:0] mctrl_q, mctrl_d, sctrl_q, sctrl_d;
  logic [DATA_W-1:0] mdata_q, mdata_d, sdata_q, sdata_d;
  logic              accept;

  assign up_ready = SKID ? !sv_q : (!mv_q || dn_ready);
  assign accept   = up_valid && up_ready;
  assign dn_valid = mv_q;
  assign dn_ctrl  = mv_q ? mctrl_q : '0;
  assign dn_data  = mdata_q;

  always_comb begin
    mv_d    = mv_q;
    sv_d    = sv_q;
    mctrl_d = mctrl_q;
    sctrl_d = sctrl_q;
    mdata_d = mdata_q;
    sdata_d = sdata_q;
    // Flush drops everything, including a same-cycle accept; data is left in place
    if (flush) begin
      mv_d    = 1'b0;
      sv_d    = 1'b0;
      mctrl_d = '0;
      sctrl_d = '0;
    end else if (mv_q && dn_ready) begin
      if (sv_q) begin
        mctrl_d = sctrl_q;
        mdata_d = sdata_q;
        sv_d    = 1'b0;
        sctrl_d = '0;
      end else if (accept) begin
        mctrl_d = up_ctrl;
        mdata_d = up_data;
      end else begin
        mv_d    = 1'b0;
        mctrl_d = '0;
      end
    end else if (!mv_q) begin
      if (accept) begin
        mv_d    = 1'b1;
        mctrl_d = up_ctrl;
        mdata_d = up_data;
      end
    end else if (accept) begin
      sv_d    = 1'b1;
      sctrl_d = up_ctrl;
      sdata_d = up_data;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mv_q    <= 1'b0;
      sv_q    <= 1'b0;
      mctrl_q <= '0;
      sctrl_q <= '0;
      mdata_q <= '0;
      sdata_q <= '0;
    end else begin
      mv_q    <= mv_d;
      sv_q    <= sv_d;
      mctrl_q <= mctrl_d;
      sctrl_q <= sctrl_d;
      mdata_q <= mdata_d;
      sdata_q <= sdata_d;
    end
  end

endmodule

// File: rtl/pipe_hs_stage.sv
// rtl/pipe_hs_stage.sv - chain of handshake slots plus saturating stall counter
module pipe_hs_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int STAGES = 1,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_stats
);

  localparam int N = clamp_stages(STAGES);

  logic [N:0]             vld, rdy;
  logic [N:0][CTRL_W-1:0] ctl;
  logic [N:0][DATA_W-1:0] dat;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  assign vld[0]    = in_valid;
  assign ctl[0]    = in_ctrl;
  assign dat[0]    = in_data;
  assign in_ready  = rdy[0];
  assign rdy[N]    = out_ready;
  assign out_valid = vld[N];
  assign out_ctrl  = ctl[N];
  assign out_data  = dat[N];
  assign stall_cnt = stall_cnt_q;

  for (genvar k = 0; k < N; k++) begin : gen_slot
    pipe_hs_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(SKID)) u_slot (
      .clk      (clk),
      .clrn     (clrn),
      .flush    (flush),
      .up_valid (vld[k]),
      .up_ready (rdy[k]),
      .up_ctrl  (ctl[k]),
      .up_data  (dat[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_ctrl  (ctl[k+1]),
      .dn_data  (dat[k+1])
    );
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hs_stage.sv
// tb/tb_pipe_hs_stage.sv - scoreboard bench for pipe_hs_stage in three configurations
module tb_pipe_hs_stage;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        in_valid [3];
  logic        in_ready [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        flush [3];
  logic        clr_stats [3];
  logic [15:0] in_ctrl [3];
  logic [15:0] out_ctrl [3];
  logic [63:0] in_data [3];
  logic [63:0] out_data [3];
  logic [15:0] stall_a, stall_c;
  logic [3:0]  stall_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [79:0] sb [$];

  always #5 clk = ~clk;

  pipe_hs_stage #(.DATA_W(64), .CTRL_W(16), .STAGES(2), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .clrn(clrn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
    .out_data(out_data[0]), .stall_cnt(stall_a), .clr_stats(clr_stats[0])
  );

  pipe_hs_stage #(.DATA_W(64), .CTRL_W(16), .STAGES(1), .SKID(1'b1), .CNT_W(4)) u_b (
    .clk(clk), .clrn(clrn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_ctrl(in_ctrl[1]), .in_data(in_data[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
    .out_data(out_data[1]), .stall_cnt(stall_b), .clr_stats(clr_stats[1])
  );

  pipe_hs_stage #(.DATA_W(64), .CTRL_W(16), .STAGES(1), .SKID(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .clrn(clrn), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_ctrl(in_ctrl[2]), .in_data(in_data[2]), .flush(flush[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_ctrl(out_ctrl[2]),
    .out_data(out_data[2]), .stall_cnt(stall_c), .clr_stats(clr_stats[2])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ctrl_of(input logic [63:0] d);
    return 16'h8000 | (d[15:0] * 16'd3 + 16'd1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [63:0] d);
    in_valid[i] = v;
    in_data[i]  = d;
    in_ctrl[i]  = v ? ctrl_of(d) : 16'h0;
  endtask

  // Handshakes are sampled mid-cycle: what is seen here is what transfers at the next edge
  always @(negedge clk) begin
    logic [79:0] e;
    if (!clrn) begin
      sb.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!out_valid[i]) begin
          check($sformatf("bubble_ctrl%0d", i), 64'(out_ctrl[i]), 64'h0);
        end else if (out_ready[i]) begin
          if (sb.size() == 0) begin
            check($sformatf("sb_underflow%0d", i), 64'(sb.size()), 64'd1);
          end else begin
            e = sb.pop_front();
            check($sformatf("out_data%0d", i), out_data[i], e[63:0]);
            check($sformatf("out_ctrl%0d", i), 64'(out_ctrl[i]), 64'(e[79:64]));
          end
        end
        if (flush[i]) begin
          sb.delete();
        end else if (in_valid[i] && in_ready[i]) begin
          sb.push_back({in_ctrl[i], in_data[i]});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_out_valid%0d", tag, i), 64'(out_valid[i]), 64'd0);
      check($sformatf("%s_out_ctrl%0d", tag, i), 64'(out_ctrl[i]), 64'd0);
      check($sformatf("%s_out_data%0d", tag, i), out_data[i], 64'd0);
      check($sformatf("%s_in_ready%0d", tag, i), 64'(in_ready[i]), 64'd1);
    end
    check({tag, "_stall_a"}, 64'(stall_a), 64'd0);
    check({tag, "_stall_b"}, 64'(stall_b), 64'd0);
    check({tag, "_stall_c"}, 64'(stall_c), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(i, 1'b0, 64'd0);
      out_ready[i] = 1'b1;
      flush[i]     = 1'b0;
      clr_stats[i] = 1'b0;
    end
    #12;
    check_reset_state("por");
    step();
    clrn = 1'b1;

    // Streaming through two slots, no backpressure
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1'b1, 64'(k));
      check("a_in_ready", 64'(in_ready[0]), 64'd1);
      step();
      if (k == 1) check("a_lat1_valid", 64'(out_valid[0]), 64'd0);
      if (k == 2) begin
        check("a_lat2_valid", 64'(out_valid[0]), 64'd1);
        check("a_lat2_data", out_data[0], 64'd1);
      end
    end
    drive(0, 1'b0, 64'd0);
    repeat (3) step();
    check("a_drained", 64'(sb.size()), 64'd0);
    check("a_hold_data", out_data[0], 64'd8);
    check("a_no_stall", 64'(stall_a), 64'd0);

    // Backpressure into a single skid slot
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 64'd1);
    step();
    check("b_stall0", 64'(stall_b), 64'd0);
    check("b_ready_after1", 64'(in_ready[1]), 64'd1);
    drive(1, 1'b1, 64'd2);
    step();
    check("b_ready_after2", 64'(in_ready[1]), 64'd0);
    check("b_stall1", 64'(stall_b), 64'd1);
    drive(1, 1'b1, 64'd3);
    repeat (4) step();
    check("b_stall5", 64'(stall_b), 64'd5);
    check("b_ready_full", 64'(in_ready[1]), 64'd0);
    out_ready[1] = 1'b1;
    step();
    check("b_ready_reopen", 64'(in_ready[1]), 64'd1);
    step();
    drive(1, 1'b0, 64'd0);
    repeat (2) step();
    check("b_drained", 64'(sb.size()), 64'd0);
    check("b_stall_kept", 64'(stall_b), 64'd5);

    // Counter saturation and clear priority
    clr_stats[1] = 1'b1;
    step();
    clr_stats[1] = 1'b0;
    check("sat_clr", 64'(stall_b), 64'd0);
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 64'd9);
    step();
    drive(1, 1'b0, 64'd0);
    repeat (20) step();
    check("sat_15", 64'(stall_b), 64'd15);
    clr_stats[1] = 1'b1;
    step();
    clr_stats[1] = 1'b0;
    check("sat_clr_wins", 64'(stall_b), 64'd0);
    step();
    check("sat_resume", 64'(stall_b), 64'd1);
    out_ready[1] = 1'b1;
    repeat (2) step();
    check("sat_drained", 64'(sb.size()), 64'd0);

    // No skid: one entry, ready follows out_ready combinationally
    out_ready[2] = 1'b0;
    drive(2, 1'b1, 64'd1);
    check("c_ready_empty", 64'(in_ready[2]), 64'd1);
    step();
    drive(2, 1'b1, 64'd2);
    check("c_ready_full", 64'(in_ready[2]), 64'd0);
    out_ready[2] = 1'b1;
    #1;
    check("c_ready_comb_hi", 64'(in_ready[2]), 64'd1);
    out_ready[2] = 1'b0;
    #1;
    check("c_ready_comb_lo", 64'(in_ready[2]), 64'd0);
    repeat (2) step();
    check("c_stall2", 64'(stall_c), 64'd2);
    out_ready[2] = 1'b1;
    step();
    drive(2, 1'b1, 64'd3);
    step();
    drive(2, 1'b0, 64'd0);
    repeat (2) step();
    check("c_drained", 64'(sb.size()), 64'd0);
    check("c_stall_kept", 64'(stall_c), 64'd2);

    // Flush with three in flight and an input offered in the same cycle
    out_ready[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1'b1, 64'(k));
      check("d_ready_fill", 64'(in_ready[0]), 64'd1);
      step();
    end
    drive(0, 1'b1, 64'd4);
    flush[0]     = 1'b1;
    out_ready[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    drive(0, 1'b0, 64'd0);
    check("d_out_valid", 64'(out_valid[0]), 64'd0);
    check("d_out_ctrl", 64'(out_ctrl[0]), 64'd0);
    check("d_in_ready", 64'(in_ready[0]), 64'd1);
    check("d_data_hold", out_data[0], 64'd1);
    repeat (4) step();
    drive(0, 1'b1, 64'd5);
    step();
    drive(0, 1'b0, 64'd0);
    repeat (3) step();
    check("d_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset in the middle of traffic
    out_ready[1] = 1'b0;
    drive(1, 1'b1, 64'd7);
    step();
    drive(1, 1'b0, 64'd0);
    drive(0, 1'b1, 64'd6);
    step();
    drive(0, 1'b0, 64'd0);
    #2;
    clrn = 1'b0;
    #1;
    check_reset_state("mid");
    out_ready[1] = 1'b1;
    step();
    clrn = 1'b1;
    for (int k = 10; k <= 11; k++) begin
      drive(0, 1'b1, 64'(k));
      step();
    end
    drive(0, 1'b0, 64'd0);
    repeat (3) step();
    check("e_drained", 64'(sb.size()), 64'd0);
    check("e_last_data", out_data[0], 64'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
